// File: rtl/uart_rx_cmd_parser.sv
// ASCII command-frame decoder: "S"+4 hex or "B"+2 hex, then CR/LF, sets the
// switch/button images; malformed frames pulse frame_error and bump error_count.
module uart_rx_cmd_parser #(
  parameter int DATA_WIDTH     = 8,
  parameter int SWITCH_COUNT   = 16,
  parameter int BUTTON_COUNT   = 5,
  parameter int TIMEOUT_CYCLES = 434000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ena,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [SWITCH_COUNT-1:0] switch_data,
  output logic [BUTTON_COUNT-1:0] button_data,
  output logic                    switch_update,
  output logic                    button_update,
  output logic                    frame_error,
  output logic [7:0]              error_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] CH_CR = DATA_WIDTH'(8'h0D);
  localparam logic [DATA_WIDTH-1:0] CH_LF = DATA_WIDTH'(8'h0A);
  localparam logic [DATA_WIDTH-1:0] CH_SP = DATA_WIDTH'(8'h20);
  localparam logic [DATA_WIDTH-1:0] CH_0  = DATA_WIDTH'(8'h30);
  localparam logic [DATA_WIDTH-1:0] CH_9  = DATA_WIDTH'(8'h39);
  localparam logic [DATA_WIDTH-1:0] CH_UA = DATA_WIDTH'(8'h41);
  localparam logic [DATA_WIDTH-1:0] CH_UF = DATA_WIDTH'(8'h46);
  localparam logic [DATA_WIDTH-1:0] CH_LA = DATA_WIDTH'(8'h61);
  localparam logic [DATA_WIDTH-1:0] CH_LF_HEX = DATA_WIDTH'(8'h66);
  localparam logic [DATA_WIDTH-1:0] CH_US = DATA_WIDTH'(8'h53);
  localparam logic [DATA_WIDTH-1:0] CH_LS = DATA_WIDTH'(8'h73);
  localparam logic [DATA_WIDTH-1:0] CH_UB = DATA_WIDTH'(8'h42);
  localparam logic [DATA_WIDTH-1:0] CH_LB = DATA_WIDTH'(8'h62);

  typedef enum logic [1:0] {IDLE, DIGITS, TERM} state_t;

  state_t                  state, state_n;
  logic                    typ_b, typ_b_n;
  logic [15:0]             acc, acc_n;
  logic [2:0]              cnt, cnt_n;
  logic [TW-1:0]           tmo, tmo_n;
  logic [SWITCH_COUNT-1:0] sw_n;
  logic [BUTTON_COUNT-1:0] bt_n;
  logic                    swu_n, btu_n, err_n;
  logic [7:0]              ec_n;

  // Character classification
  logic       is_dig, is_uc, is_lc, is_hex, is_s, is_b, is_term, is_ws, expired, btn_ok;
  logic [3:0] nibble;
  logic [2:0] need;

  assign rx_ready = ena & ~reset;

  always_comb begin
    is_dig  = (rx_data >= CH_0)  && (rx_data <= CH_9);
    is_uc   = (rx_data >= CH_UA) && (rx_data <= CH_UF);
    is_lc   = (rx_data >= CH_LA) && (rx_data <= CH_LF_HEX);
    is_hex  = is_dig | is_uc | is_lc;
    nibble  = is_dig ? rx_data[3:0] : 4'(rx_data[3:0] + 4'd9);
    is_s    = (rx_data == CH_US) || (rx_data == CH_LS);
    is_b    = (rx_data == CH_UB) || (rx_data == CH_LB);
    is_term = (rx_data == CH_CR) || (rx_data == CH_LF);
    is_ws   = is_term || (rx_data == CH_SP);
    need    = typ_b ? 3'd2 : 3'd4;
    // A byte arriving on the expiry cycle takes priority over the timeout
    expired = (state != IDLE) && (tmo == TMO_MAX) && !rx_valid;
    btn_ok  = ((acc[7:0] >> BUTTON_COUNT) == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      typ_b         <= 1'b0;
      acc           <= '0;
      cnt           <= '0;
      tmo           <= '0;
      switch_data   <= '0;
      button_data   <= '0;
      switch_update <= 1'b0;
      button_update <= 1'b0;
      frame_error   <= 1'b0;
      error_count   <= '0;
    end else begin
      state         <= state_n;
      typ_b         <= typ_b_n;
      acc           <= acc_n;
      cnt           <= cnt_n;
      tmo           <= tmo_n;
      switch_data   <= sw_n;
      button_data   <= bt_n;
      switch_update <= swu_n;
      button_update <= btu_n;
      frame_error   <= err_n;
      error_count   <= ec_n;
    end
  end

  always_comb begin
    state_n = state;
    if (ena) begin
      case (state)
        IDLE:    if (rx_valid && (is_s || is_b)) state_n = DIGITS;
        DIGITS:  if (rx_valid) state_n = !is_hex ? IDLE :
                                         ((cnt + 3'd1) == need) ? TERM : DIGITS;
                 else if (expired) state_n = IDLE;
        TERM:    if (rx_valid || expired) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    typ_b_n = typ_b;
    acc_n   = acc;
    cnt_n   = cnt;
    tmo_n   = tmo;
    sw_n    = switch_data;
    bt_n    = button_data;
    swu_n   = 1'b0;
    btu_n   = 1'b0;
    err_n   = 1'b0;
    if (ena) begin
      tmo_n = (state == IDLE || rx_valid || expired) ? '0 : tmo + TW'(1);
      case (state)
        IDLE: if (rx_valid) begin
          if (is_s || is_b) begin
            typ_b_n = is_b;
            acc_n   = '0;
            cnt_n   = '0;
          end else if (!is_ws) err_n = 1'b1;
        end
        DIGITS: if (rx_valid) begin
          if (is_hex) begin
            acc_n = {acc[11:0], nibble};
            cnt_n = cnt + 3'd1;
          end else err_n = 1'b1;
        end else if (expired) err_n = 1'b1;
        TERM: if (rx_valid) begin
          if (!is_term) err_n = 1'b1;
          else if (!typ_b) begin
            sw_n  = acc[SWITCH_COUNT-1:0];
            swu_n = 1'b1;
          end else if (btn_ok) begin
            bt_n  = acc[BUTTON_COUNT-1:0];
            btu_n = 1'b1;
          end else err_n = 1'b1;
        end else if (expired) err_n = 1'b1;
        default: ;
      endcase
    end
    ec_n = (err_n && error_count != 8'hFF) ? error_count + 8'd1 : error_count;
  end
endmodule

// File: doc/uart_rx_cmd_parser.md
Name: uart_rx_cmd_parser

Overview:
- Consumes the byte stream from the UART receiver (rx_data/rx_valid) and decodes ASCII command frames that set the Basys3 switch and button images.
- Drives switch_data/button_data for the input value checker.
- Reports malformed frames through an error pulse and a saturating error counter.

Parameters:
- DATA_WIDTH, 8, width of a received character.
- SWITCH_COUNT, 16, width of switch_data. Fixed at 16: four hex digits.
- BUTTON_COUNT, 5, width of button_data. At most 8: two hex digits.
- TIMEOUT_CYCLES, 434000, idle clocks allowed mid-frame before abort (≈100 character times at 115200 baud, 50 MHz).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ena  input  1  design enable; when low all state holds and input bytes are ignored
- rx_data  input  DATA_WIDTH  received character
- rx_valid  input  1  one-cycle strobe, rx_data valid
- rx_ready  output  1  parser can accept a byte; equals ena & ~reset
- switch_data  output  SWITCH_COUNT  last committed switch image
- button_data  output  BUTTON_COUNT  last committed button image
- switch_update  output  1  one-cycle pulse when switch_data changes by commit
- button_update  output  1  one-cycle pulse when button_data changes by commit
- frame_error  output  1  one-cycle pulse on any frame abort
- error_count  output  8  saturating count of frame_error pulses

Behaviour:
- Reset values (on reset=1 at a clk edge):
  - switch_data=0, button_data=0, all pulses 0, error_count=0.
  - State IDLE, accumulator 0, digit counter 0, timeout counter 0.
  - Reset mid-frame discards the partial frame and does not raise frame_error.
- Byte acceptance: a byte is accepted on a clk edge with ena=1 and rx_valid=1. All outputs are registered and update on the same edge (latency 1 clock from the accepting edge). Pulses last exactly one cycle.
- Frame grammar: a frame is a type char, then exactly N hex digits, then a terminator.
  - Type 'S'/'s' (0x53/0x73): N=4.
  - Type 'B'/'b' (0x42/0x62): N=2.
  - Hex digits: 0-9, A-F, a-f.
  - Terminator: CR 0x0D or LF 0x0A.
- IDLE:
  - Type char: latch type, clear accumulator and digit counter, go to DIGITS.
  - CR/LF/space (0x20): ignored, stay IDLE.
  - Any other byte: frame_error, stay IDLE.
- DIGITS:
  - Hex digit: acc <= {acc[11:0], nibble}, count+1. When count reaches N, go to TERM.
  - Non-hex byte, including a terminator arriving early: frame_error, go to IDLE.
  - 'B'/'b' inside DIGITS is the hex digit 0xB.
- TERM:
  - Terminator, type S: switch_data <= acc[15:0], switch_update=1, go to IDLE.
  - Terminator, type B:
    - If acc[7:BUTTON_COUNT]==0: button_data <= acc[BUTTON_COUNT-1:0], button_update=1.
    - Otherwise frame_error and button_data is unchanged.
    - In both cases go to IDLE.
  - Any other byte: frame_error, go to IDLE.
- Update pulses fire on every commit, including when the committed value equals the current value.
- Timeout:
  - The counter runs only in DIGITS/TERM with ena=1. It clears on every accepted byte and on entry to IDLE.
  - Reaching TIMEOUT_CYCLES-1 with no byte that cycle: frame_error, go to IDLE.
  - A byte accepted on the expiry cycle wins: the byte is processed and the timeout does not fire.
- error_count: increments on each frame_error and saturates at 255 (no wrap).
- ena=0: state, counters and outputs hold; rx_valid is ignored. Any pulse already high drops to 0 on the next edge.

Test Plan:
- Reset, then send "S1A2F\n" -> after the LF edge switch_data=0x1A2F, one-cycle switch_update, frame_error never asserted, error_count=0.
- Send "b1F\r" then "B20\r" -> button_data=0x1F with button_update. The second frame gives frame_error, button_data stays 0x1F, error_count=1.
- Send "S12\n" (early terminator), then "SABCDX" -> two frame_error pulses, switch_data unchanged, error_count=2. Then "sbeef\n" -> switch_data=0xBEEF.
- Send "S12" then idle TIMEOUT_CYCLES clocks -> frame_error exactly once, state IDLE. Then "S0001\n" -> switch_data=0x0001. Repeat with a digit arriving on the expiry cycle -> no error.
- Send 300 invalid bytes 'Z' -> error_count saturates at 255. Assert reset mid-frame ("S12", reset) -> all outputs 0, no frame_error.
- Hold ena=0 while strobing "S5555\n" -> no output change. With ena=1, "S5555\n" -> switch_data=0x5555.
